// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } ps2_state_e;

  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Generic show-ahead FIFO: head entry is always visible on pop_data.
module ps2_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop frees the head slot on the same edge, so a push at full is still accepted.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + deglitch, 11-bit framing with checks,
// bit-gap timeout, and a show-ahead byte FIFO behind valid/ready.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ps2_clock,
  input  logic             ps2_data,
  output logic             code_valid,
  output logic [7:0]       code_data,
  input  logic             code_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             parity_err,
  output logic             frame_err,
  output logic             timeout_err,
  output logic             overflow
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          fall, data_s;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          parity_err_d, frame_err_d, timeout_err_d, overflow_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign data_s = dat_sync_q[1];

  // Filtered clock moves only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d    = filt_q;
    flt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
  end

  assign fall = filt_q & ~filt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      flt_cnt_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clock};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_q     <= filt_d;
      flt_cnt_q  <= flt_cnt_d;
    end
  end

  assign fifo_pop   = code_valid & code_ready;
  assign code_valid = ~fifo_empty;

  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    rx_byte_d     = rx_byte_q;
    par_ok_d      = par_ok_q;
    tmo_cnt_d     = tmo_cnt_q;
    fifo_push     = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    overflow_d    = 1'b0;
    // A fall on the terminal-count cycle takes precedence over the timeout.
    if (fall) begin
      tmo_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (data_s == START_BIT) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        StData: begin
          rx_byte_d[bit_idx_q] = data_s;
          if (bit_idx_q == 3'd7) begin
            state_d = StParity;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        StParity: begin
          par_ok_d = data_s ^ (^rx_byte_q);
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (data_s != STOP_BIT) begin
            frame_err_d = 1'b1;
          end else if (!par_ok_q) begin
            parity_err_d = 1'b1;
          end else begin
            fifo_push  = 1'b1;
            overflow_d = fifo_full & ~fifo_pop;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q == StIdle) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d       = StIdle;
      bit_idx_d     = '0;
      tmo_cnt_d     = '0;
      timeout_err_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_idx_q   <= '0;
      rx_byte_q   <= '0;
      par_ok_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      rx_byte_q   <= rx_byte_d;
      par_ok_q    <= par_ok_d;
      tmo_cnt_q   <= tmo_cnt_d;
      parity_err  <= parity_err_d;
      frame_err   <= frame_err_d;
      timeout_err <= timeout_err_d;
      overflow    <= overflow_d;
    end
  end

  ps2_sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(rx_byte_q),
    .pop      (fifo_pop),
    .pop_data (code_data),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scenario bench for ps2_rx_fifo with a scoreboard of expected scan codes.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int HALF  = 20;
  localparam int LAT   = 2 + FL;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ps2_clock = 1'b1;
  logic          ps2_data = 1'b1;
  logic          code_ready = 1'b0;
  logic          code_valid;
  logic [7:0]    code_data;
  logic [CW-1:0] fifo_count;
  logic          parity_err, frame_err, timeout_err, overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int n_par = 0, n_frm = 0, n_tmo = 0, n_ovf = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_head;

  ps2_rx_fifo #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (DEPTH),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .code_valid (code_valid),
    .code_data  (code_data),
    .code_ready (code_ready),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (!reset) begin
      if (parity_err)  n_par++;
      if (frame_err)   n_frm++;
      if (timeout_err) n_tmo++;
      if (overflow)    n_ovf++;
      if (code_valid && code_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got %02h, required no output", code_data);
        end else begin
          exp_head = exp_q.pop_front();
          if (code_data !== exp_head) begin
            n_fail++;
            $display("FAIL pop_data: got %02h, required %02h", code_data, exp_head);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic flip, input logic stop);
    return {stop, (~^b) ^ flip, b, START_BIT};
  endfunction

  // Sets data, holds clock high for a half period, then drops the clock.
  task automatic bit_high(input logic d, input bit glitch);
    ps2_data = d;
    if (glitch) begin
      repeat (HALF / 2) tick();
      ps2_clock = 1'b0;
      repeat (FL / 2) tick();
      ps2_clock = 1'b1;
      repeat (HALF - HALF / 2 - FL / 2) tick();
    end else begin
      repeat (HALF) tick();
    end
    ps2_clock = 1'b0;
  endtask

  task automatic bit_low(input int done);
    repeat (HALF - done) tick();
    ps2_clock = 1'b1;
  endtask

  task automatic frame_tail();
    ps2_data = 1'b1;
    repeat (HALF) tick();
  endtask

  task automatic drive_frame(input logic [10:0] f, input bit glitch);
    for (int i = 0; i < FRAME_BITS; i++) begin
      bit_high(f[i], glitch);
      bit_low(0);
    end
    frame_tail();
  endtask

  task automatic check(input string name, input int got, input int req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    check("reset_valid", int'(code_valid), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_data", int'(code_data), 0);
    check("reset_pulses", int'({parity_err, frame_err, timeout_err, overflow}), 0);
    reset = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_good_frame();
    logic [10:0] f;
    int errs;
    errs = n_par + n_frm + n_tmo + n_ovf;
    code_ready = 1'b1;
    f = mk(8'h1C, 1'b0, 1'b1);
    exp_q.push_back(8'h1C);
    for (int i = 0; i < FRAME_BITS - 1; i++) begin
      bit_high(f[i], 1'b0);
      bit_low(0);
    end
    bit_high(f[10], 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) check("valid_before_stop", int'(code_valid), 0);
      if (k == LAT) begin
        check("valid_after_stop", int'(code_valid), 1);
        check("data_after_stop", int'(code_data), 'h1C);
      end
    end
    bit_low(LAT);
    frame_tail();
    check("good_count_zero", int'(fifo_count), 0);
    check("good_all_popped", exp_q.size(), 0);
    check("good_no_errors", n_par + n_frm + n_tmo + n_ovf, errs);
  endtask

  task automatic test_errors();
    int p0, f0, o0;
    p0 = n_par;
    f0 = n_frm;
    o0 = n_ovf + n_tmo;
    code_ready = 1'b1;
    drive_frame(mk(8'hF0, 1'b1, 1'b1), 1'b0);
    check("parity_err_pulses", n_par, p0 + 1);
    check("parity_no_frame_err", n_frm, f0);
    check("parity_count", int'(fifo_count), 0);
    drive_frame(mk(8'h12, 1'b0, 1'b0), 1'b0);
    check("frame_err_pulses", n_frm, f0 + 1);
    check("frame_no_parity_err", n_par, p0 + 1);
    check("errors_no_other", n_ovf + n_tmo, o0);
    check("errors_count", int'(fifo_count), 0);
  endtask

  task automatic test_glitch();
    int errs;
    errs = n_par + n_frm + n_tmo + n_ovf;
    code_ready = 1'b1;
    exp_q.push_back(8'h5A);
    drive_frame(mk(8'h5A, 1'b0, 1'b1), 1'b1);
    check("glitch_decoded", exp_q.size(), 0);
    check("glitch_no_errors", n_par + n_frm + n_tmo + n_ovf, errs);
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    int t0;
    t0 = n_tmo;
    code_ready = 1'b1;
    f = mk(8'hA5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bit_high(f[i], 1'b0);
      bit_low(0);
    end
    bit_high(f[4], 1'b0);
    for (int k = 1; k <= LAT + TO + 1; k++) begin
      tick();
      if (k == HALF) begin
        ps2_clock = 1'b1;
        ps2_data  = 1'b1;
      end
      if (k == LAT + TO - 1) check("timeout_not_early", int'(timeout_err), 0);
      if (k == LAT + TO) check("timeout_on_time", int'(timeout_err), 1);
    end
    repeat (5) tick();
    check("timeout_one_pulse", n_tmo, t0 + 1);
    exp_q.push_back(8'h29);
    drive_frame(mk(8'h29, 1'b0, 1'b1), 1'b0);
    check("after_timeout_decoded", exp_q.size(), 0);
    check("after_timeout_no_more", n_tmo, t0 + 1);
  endtask

  task automatic test_overflow();
    logic [10:0] f;
    int o0;
    o0 = n_ovf;
    code_ready = 1'b0;
    for (int v = 1; v <= DEPTH + 1; v++) begin
      if (v <= DEPTH) exp_q.push_back(8'(v));
      drive_frame(mk(8'(v), 1'b0, 1'b1), 1'b0);
    end
    check("ovf_count_full", int'(fifo_count), DEPTH);
    check("ovf_one_pulse", n_ovf, o0 + 1);
    check("ovf_head", int'(code_data), 'h01);
    // Pop exactly on the stop-bit fall while full.
    f = mk(8'h06, 1'b0, 1'b1);
    exp_q.push_back(8'h06);
    for (int i = 0; i < FRAME_BITS - 1; i++) begin
      bit_high(f[i], 1'b0);
      bit_low(0);
    end
    bit_high(f[10], 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) code_ready = 1'b1;
      if (k == LAT) begin
        code_ready = 1'b0;
        check("full_pushpop_count", int'(fifo_count), DEPTH);
        check("full_pushpop_no_ovf", int'(overflow), 0);
      end
    end
    bit_low(LAT);
    frame_tail();
    check("full_pushpop_ovf_total", n_ovf, o0 + 1);
    check("full_pushpop_head", int'(code_data), 'h02);
    code_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    check("drain_count", int'(fifo_count), 0);
    check("drain_all_seen", exp_q.size(), 0);
  endtask

  task automatic test_reset_mid();
    logic [10:0] f;
    int errs;
    code_ready = 1'b0;
    for (int v = 'h31; v <= 'h33; v++) begin
      exp_q.push_back(8'(v));
      drive_frame(mk(8'(v), 1'b0, 1'b1), 1'b0);
    end
    check("pre_reset_count", int'(fifo_count), 3);
    f = mk(8'h44, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_high(f[i], 1'b0);
      bit_low(0);
    end
    reset = 1'b1;
    tick();
    check("mid_reset_valid", int'(code_valid), 0);
    check("mid_reset_count", int'(fifo_count), 0);
    check("mid_reset_data", int'(code_data), 0);
    check("mid_reset_pulses", int'({parity_err, frame_err, timeout_err, overflow}), 0);
    exp_q.delete();
    ps2_data = 1'b1;
    tick();
    reset = 1'b0;
    errs = n_par + n_frm + n_tmo + n_ovf;
    repeat (TO + LAT + 10) tick();
    check("post_reset_no_pulses", n_par + n_frm + n_tmo + n_ovf, errs);
    code_ready = 1'b1;
    exp_q.push_back(8'h76);
    drive_frame(mk(8'h76, 1'b0, 1'b1), 1'b0);
    check("post_reset_decoded", exp_q.size(), 0);
    check("post_reset_count", int'(fifo_count), 0);
    check("post_reset_clean", n_par + n_frm + n_tmo + n_ovf, errs);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_glitch();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver, the next generation of our scan-code decoder. It synchronises and deglitches the PS/2 clock and data lines and frames 11-bit packets with start, parity and stop checks. Frames are abandoned after a bit-gap timeout, and good bytes are buffered in a show-ahead FIFO behind a valid/ready handshake. It sits between the PS/2 pins and the keyboard/mouse decode logic.

## Interface
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered PS/2 clock changes (≥1)
- TIMEOUT_CYCLES, 5000: clk cycles without a filtered falling edge, mid-frame, before the frame is abandoned (≥2)
- FIFO_DEPTH, 16: byte entries; power of two, ≥2
- CNT_W, $clog2(FIFO_DEPTH)+1: derived width of fifo_count

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- ps2_clock  in  1  raw PS/2 clock pin
- ps2_data  in  1  raw PS/2 data pin
- code_valid  out  1  FIFO non-empty; code_data is valid
- code_data  out  8  head-of-FIFO scan code
- code_ready  in  1  consumer accepts code_data when high with code_valid
- fifo_count  out  CNT_W  current occupancy, 0..FIFO_DEPTH
- parity_err  out  1  one-cycle pulse: odd parity failed, byte dropped
- frame_err  out  1  one-cycle pulse: start bit 1 or stop bit 0, byte dropped
- timeout_err  out  1  one-cycle pulse: frame abandoned by timeout
- overflow  out  1  one-cycle pulse: good byte dropped, FIFO full

## Operation
- Clock and data each pass through a 2-flop synchroniser.
- The filtered clock (reset value 1) takes the synchronised value after FILTER_LEN consecutive equal samples. Data is synchronised only, not filtered.
- A falling edge is a 1→0 transition of the filtered clock. It generates a one-cycle `fall` strobe, and the synchronised data is sampled on that cycle.
- FSM states (ps2_pkg): IDLE, DATA, PARITY, STOP.
  - IDLE, on fall: if data=0, go to DATA with bit index 0. If data=1, pulse frame_err and stay in IDLE.
  - DATA, on fall: shift data into bit[index], LSB first. After index 7, go to PARITY.
  - PARITY, on fall: latch parity_ok = (data XOR ^byte) == 1. Go to STOP.
  - STOP, on fall: return to IDLE.
    - data=0: frame_err.
    - Else if !parity_ok: parity_err.
    - Else push the byte into the FIFO. If the FIFO is full with no pop this cycle, drop the byte and pulse overflow instead.
  - Only one error pulse fires per frame. frame_err takes priority over parity_err.
- Timeout counter:
  - Cleared on every fall and in IDLE.
  - Increments otherwise.
  - On reaching TIMEOUT_CYCLES: FSM→IDLE, partial byte discarded, timeout_err pulses, counter clears.
  - A fall on the same cycle as the terminal count wins: it is processed and timeout is not raised.
- FIFO, show-ahead:
  - code_data = mem[rd_ptr].
  - Pop when code_valid && code_ready.
  - Push and pop may occur in the same cycle. When full, that combination is accepted and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset, asserted at any time including mid-frame:
  - FSM→IDLE; counters, pointers, fifo_count and all pulses go to 0. code_valid=0 and code_data=0.
  - Synchroniser and filter flops go to 1 (bus idle).
  - FIFO contents are lost.

## Timing
- Pin-to-fall latency: 2 (sync) + FILTER_LEN cycles.
- Push occurs on the stop-bit fall cycle. code_valid and fifo_count update on the next clk edge, so the byte is visible 1 cycle after the stop-bit fall.
- Pop: code_data shows the next entry the cycle after the accepting edge.
- Error and overflow pulses are registered. Each is high for exactly the one cycle after the triggering fall or timeout.
- Throughput: one byte per 11 PS/2 bit periods. The consumer may hold code_ready low indefinitely; overflow is the only consequence.

## Structure
- ps2_pkg holds:
  - the state enum (IDLE, DATA, PARITY, STOP);
  - START_BIT=0 and STOP_BIT=1;
  - FRAME_BITS=11.
- Natural sub-module: ps2_sync_fifo. It is a generic show-ahead FIFO parametrised by WIDTH and DEPTH, with count output, full/empty flags, and push/pop handling when simultaneous.
- The synchroniser/filter and the FSM stay in the top module.

## Test plan
- Send frame for 0x1C (odd parity bit 0), code_ready=1 → code_valid one cycle after stop fall, code_data=0x1C, no error pulses, fifo_count returns to 0.
- Send 0xF0 with parity bit flipped → parity_err one pulse, fifo_count stays 0. Send 0x12 with stop bit 0 → frame_err pulse only.
- Inject 0.5×FILTER_LEN-cycle low glitches on ps2_clock mid-bit during frame 0x5A → decoded 0x5A, no errors.
- Stop clocking after 4 data bits → timeout_err exactly TIMEOUT_CYCLES after last fall; the following clean frame 0x29 decodes correctly.
- code_ready=0, send FIFO_DEPTH+1 frames 0x01..0x11 → fifo_count=FIFO_DEPTH, one overflow pulse; drain yields 0x01..0x10 in order. Pop on the same cycle as a push at full → count unchanged, no overflow.
- Assert reset mid-frame (after bit 3) and with 3 bytes queued → code_valid=0, fifo_count=0, no pulses; the next frame 0x76 decodes cleanly.
